// File: rtl/v74x139_dual_decoder.sv
// Registered dual 2-to-4 decoder with active-low enables and outputs.
// Each section is decoded and registered on its own.
module v74x139_dual_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       G1,
  input  logic       G2,
  input  logic       B1,
  input  logic       A1,
  input  logic       B2,
  input  logic       A2,
  output logic [3:0] Y1,
  output logic [3:0] Y2
);

  logic [3:0] y1_next;
  logic [3:0] y2_next;

  // Active-low one-hot; a disabled section forces all outputs high.
  function automatic logic [3:0] decode(
    input logic       g,
    input logic [1:0] s
  );
    logic [3:0] y;
    y = 4'b1111;
    if (g == 1'b0) begin
      case (s)
        2'd0:    y = 4'b1110;
        2'd1:    y = 4'b1101;
        2'd2:    y = 4'b1011;
        2'd3:    y = 4'b0111;
        default: y = 4'bxxxx;
      endcase
    end else if (g !== 1'b1) begin
      y = 4'bxxxx;
    end
    return y;
  endfunction

  always_comb begin
    y1_next = decode(G1, {B1, A1});
    y2_next = decode(G2, {B2, A2});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Y1 <= 4'b1111;
      Y2 <= 4'b1111;
    end else begin
      Y1 <= y1_next;
      Y2 <= y2_next;
    end
  end

endmodule

// File: tb/tb_v74x139_dual_decoder.sv
// Directed self-checking bench for v74x139_dual_decoder.
// Expected values come from a hand-written table in the bench.
module tb_v74x139_dual_decoder;

  logic       clk;
  logic       reset;
  logic       G1, G2, B1, A1, B2, A2;
  logic [3:0] Y1, Y2;

  int errors = 0;
  int checks = 0;

  v74x139_dual_decoder dut (
    .clk   (clk),
    .reset (reset),
    .G1    (G1),
    .G2    (G2),
    .B1    (B1),
    .A1    (A1),
    .B2    (B2),
    .A2    (A2),
    .Y1    (Y1),
    .Y2    (Y2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_dec(
    input logic g, input logic b, input logic a
  );
    logic [3:0] tbl [4];
    tbl[0] = 4'b1110;
    tbl[1] = 4'b1101;
    tbl[2] = 4'b1011;
    tbl[3] = 4'b0111;
    if (g) return 4'b1111;
    return tbl[{b, a}];
  endfunction

  task automatic chk(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] e1, e2;
  logic [5:0] v;

  initial begin
    reset = 1'b1;
    G1 = 1'b1; G2 = 1'b1;
    B1 = 1'b0; A1 = 1'b0;
    B2 = 1'b0; A2 = 1'b0;
    #2;
    chk("reset_y1", Y1, 4'b1111);
    chk("reset_y2", Y2, 4'b1111);
    edge_wait();
    chk("reset_edge_y1", Y1, 4'b1111);

    // Release with section 1 selecting 0.
    G1 = 1'b0;
    reset = 1'b0;
    edge_wait();
    chk("release_y1", Y1, 4'b1110);
    chk("release_y2", Y2, 4'b1111);

    // Asynchronous reset mid-run, no clock edge needed.
    reset = 1'b1;
    #1;
    chk("async_rst_y1", Y1, 4'b1111);
    chk("async_rst_y2", Y2, 4'b1111);
    G2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      chk("hold_rst_y1", Y1, 4'b1111);
      chk("hold_rst_y2", Y2, 4'b1111);
    end
    G2 = 1'b1;
    reset = 1'b0;

    // Section 1 sweep, section 2 disabled.
    G1 = 1'b0; G2 = 1'b1;
    {B1, A1} = 2'b00;
    edge_wait();
    chk("s1_sel0", Y1, 4'b1110);
    chk("s1_sel0_y2", Y2, 4'b1111);
    {B1, A1} = 2'b01;
    edge_wait();
    chk("s1_sel1", Y1, 4'b1101);
    chk("s1_sel1_y2", Y2, 4'b1111);
    {B1, A1} = 2'b10;
    edge_wait();
    chk("s1_sel2", Y1, 4'b1011);
    chk("s1_sel2_y2", Y2, 4'b1111);
    {B1, A1} = 2'b11;
    edge_wait();
    chk("s1_sel3", Y1, 4'b0111);
    chk("s1_sel3_y2", Y2, 4'b1111);

    // Section 2 sweep, section 1 disabled.
    G1 = 1'b1; G2 = 1'b0;
    {B2, A2} = 2'b00;
    edge_wait();
    chk("s2_sel0", Y2, 4'b1110);
    chk("s2_sel0_y1", Y1, 4'b1111);
    {B2, A2} = 2'b01;
    edge_wait();
    chk("s2_sel1", Y2, 4'b1101);
    chk("s2_sel1_y1", Y1, 4'b1111);
    {B2, A2} = 2'b10;
    edge_wait();
    chk("s2_sel2", Y2, 4'b1011);
    chk("s2_sel2_y1", Y1, 4'b1111);
    {B2, A2} = 2'b11;
    edge_wait();
    chk("s2_sel3", Y2, 4'b0111);
    chk("s2_sel3_y1", Y1, 4'b1111);

    // Both disabled, every select combination.
    G1 = 1'b1; G2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = 6'(i);
      {B1, A1, B2, A2} = v[3:0];
      edge_wait();
      chk("dis_y1", Y1, 4'b1111);
      chk("dis_y2", Y2, 4'b1111);
    end

    // All 64 input combinations; expectation trails input by one edge.
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      {G1, G2, B1, B2, A1, A2} = v;
      e1 = ref_dec(v[5], v[3], v[1]);
      e2 = ref_dec(v[4], v[2], v[0]);
      edge_wait();
      chk("exh_y1", Y1, e1);
      chk("exh_y2", Y2, e2);
    end

    // Glitches between edges must not reach the outputs.
    G1 = 1'b0; G2 = 1'b1;
    {B1, A1} = 2'b11;
    edge_wait();
    chk("glitch_pre", Y1, 4'b0111);
    B1 = 1'b0;
    A1 = 1'b0;
    #1 A1 = 1'b1;
    #1 A1 = 1'b0;
    #1 A1 = 1'b1;
    #1;
    chk("glitch_hold", Y1, 4'b0111);
    edge_wait();
    chk("glitch_edge", Y1, 4'b1101);
    chk("glitch_y2", Y2, 4'b1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
